uart_calc_top: RTL and testbench
================================

// Module: uart_calc_top
// PURPOSE
//  UART-driven 16-bit integer calculator: receives ASCII expressions on rxd (8N1),
//  evaluates signed/unsigned add, subtract or multiply, returns the result as ASCII hex on txd.
//  Chip-level block: internal UART RX, command parser/ALU and UART TX behind two serial pins.
// PARAMETERS
//  CLKS_PER_BIT  16  clock cycles per UART bit, same for RX and TX
//  OP_W          16  operand width in bits (4 hex digits); result width = 2*OP_W
// PORTS
//  clk   input  1  system clock, all logic on rising edge
//  rst   input  1  asynchronous, active-high reset
//  rxd   input  1  UART receive line, idle high, 8N1, LSB first
//  txd   output 1  UART transmit line, idle high, 8N1, LSB first
// BEHAVIOUR
//  Reset: txd=1; RX/TX/parser state machines idle; operand and result registers 0; rxd sync FFs 1.
//  RX: 2-FF synchronise rxd. Falling edge in IDLE -> START; re-check at CLKS_PER_BIT/2 (low, else IDLE).
//   Then 8 data bits sampled every CLKS_PER_BIT, mid-bit. Stop bit must read 1, else byte dropped.
//   Valid byte -> 1-cycle rx_valid pulse with rx_data to parser.
//  Parser FSM, expression "I" " " {S|U} " " A op B "=":
//   WAIT_I: 'I' -> SP1. Any other byte stays in WAIT_I.
//   SP1: ' ' -> MODE.
//   MODE: 'S'/'s' signed, 'U'/'u' unsigned -> SP2.
//   SP2: ' ' -> OPA.
//   OPA: 1..4 hex digits (0-9, a-f, A-F); each shifts in: A = {A[11:0], nibble}.
//    '+', '-' or '*' after >=1 digit -> OPB.
//   OPB: 1..4 hex digits -> B; '=' after >=1 digit -> CALC.
//   Error: unexpected byte or 5th digit -> send "E\r\n", A=B=0, return to WAIT_I; 'I' restarts.
//  CALC, 1 cycle: operands extended to 32 bits (sign-extend if S, zero-extend if U).
//   '+' A+B, '-' A-B, '*' A*B, kept modulo 2^32. Signed multiply 16x16 gives exact 32-bit product.
//  SEND: 8 uppercase hex chars MSB nibble first, then 0x0D, 0x0A (10 bytes).
//   Afterwards A=B=0, return to WAIT_I.
//   First start bit on txd within 4 clk of the '=' stop-bit sample.
//   Back-to-back bytes with no idle gap. Total response 10*10*CLKS_PER_BIT clk.
//  Bytes received while sending are ignored. Parser resumes at WAIT_I after the LF stop bit.
//  TX: start 0, 8 data LSB first, stop 1, each CLKS_PER_BIT clk. txd held 1 when idle.
//  rst asserted mid-frame: all activity aborts immediately, txd=1. No partial byte is completed.
//  Wrap-around: unsigned 0000-0001 -> FFFFFFFF. Unsigned FFFF*FFFF -> FFFE0001.
// TESTING
//  1 "I S bbb5-bbb7=" -> txd "FFFFFFFE\r\n" (-17483 - -17481 = -2)
//  2 Then, after 2400 clk idle, "I S fff3-0004=" -> "FFFFFFEF\r\n" (-13-4 = -17)
//  3 "I U ffff*ffff=" -> "FFFE0001\r\n"; "I S ffff*ffff=" -> "00000001\r\n"
//  4 "I S 7fff+0001=" -> "00008000\r\n" (no 16-bit overflow); "I U 12+3=" -> "00000015\r\n"
//  5 "I S 12g4..." -> "E\r\n", next valid expression evaluated correctly
//  6 Bad stop bit and rst pulse mid-byte -> frame dropped, txd=1, next command OK

Source files
------------

// File: rtl/uart_calc_top.sv
// uart_calc_top: UART-driven 16-bit integer calculator.
// Receives "I {S|U} A{+|-|*}B=" as 8N1 ASCII on rxd and replies on txd with
// the 32-bit result as 8 uppercase hex digits plus CR LF, or "E\r\n" when the
// expression is malformed.
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous active-high reset
//   rxd - UART receive line (idle high, 8N1, LSB first)
//   txd - UART transmit line (idle high, 8N1, LSB first)
module uart_calc_top #(
    parameter int CLKS_PER_BIT = 16,
    parameter int OP_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic txd
);
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int RW   = 2 * OP_W;
    localparam int NDIG = OP_W / 4;
    localparam int NCHR = RW / 4;
    localparam int IW   = $clog2(NCHR + 3);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_st_t;
    typedef enum logic [3:0] {P_WAIT_I, P_SP1, P_MODE, P_SP2, P_OPA, P_OPB,
                              P_CALC, P_SEND, P_DRAIN} p_st_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL} op_t;

    // Hex digit decode: {valid, nibble}
    function automatic logic [4:0] hex_val(input logic [7:0] c);
        logic [7:0] t;
        t = 8'h00;
        if (c >= "0" && c <= "9") return {1'b1, c[3:0]};
        if (c >= "a" && c <= "f") begin t = c - 8'h57; return {1'b1, t[3:0]}; end
        if (c >= "A" && c <= "F") begin t = c - 8'h37; return {1'b1, t[3:0]}; end
        return 5'd0;
    endfunction

    function automatic logic [7:0] hex_chr(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // ---------------- state ----------------
    logic            rx_s1_q, rx_s2_q, rx_prev_q;
    ser_st_t         rx_st_q, rx_st_d, tx_st_q, tx_st_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
    logic [7:0]      rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
    logic            rx_valid_q, rx_valid_d;
    p_st_t           p_st_q, p_st_d;
    logic [OP_W-1:0] a_q, a_d, b_q, b_d;
    logic            sgn_q, sgn_d, err_q, err_d;
    op_t             op_q, op_d;
    logic [3:0]      ndig_q, ndig_d;
    logic [RW-1:0]   res_q, res_d;
    logic [IW-1:0]   idx_q, idx_d;

    logic            tx_ready, tx_start, bad;
    logic [7:0]      tx_byte;
    logic [4:0]      rx_hex;
    logic [RW-1:0]   ext_a, ext_b, rsh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q <= 1'b1;  rx_s2_q <= 1'b1;  rx_prev_q <= 1'b1;
            rx_st_q <= S_IDLE; rx_cnt_q <= '0; rx_bit_q <= '0; rx_sh_q <= '0;
            rx_valid_q <= 1'b0;
            tx_st_q <= S_IDLE; tx_cnt_q <= '0; tx_bit_q <= '0; tx_sh_q <= '0;
            p_st_q <= P_WAIT_I; a_q <= '0; b_q <= '0; sgn_q <= 1'b0; err_q <= 1'b0;
            op_q <= OP_ADD; ndig_q <= '0; res_q <= '0; idx_q <= '0;
        end else begin
            rx_s1_q <= rxd;  rx_s2_q <= rx_s1_q;  rx_prev_q <= rx_s2_q;
            rx_st_q <= rx_st_d; rx_cnt_q <= rx_cnt_d; rx_bit_q <= rx_bit_d; rx_sh_q <= rx_sh_d;
            rx_valid_q <= rx_valid_d;
            tx_st_q <= tx_st_d; tx_cnt_q <= tx_cnt_d; tx_bit_q <= tx_bit_d; tx_sh_q <= tx_sh_d;
            p_st_q <= p_st_d; a_q <= a_d; b_q <= b_d; sgn_q <= sgn_d; err_q <= err_d;
            op_q <= op_d; ndig_q <= ndig_d; res_q <= res_d; idx_q <= idx_d;
        end
    end

    // ---------------- UART RX ----------------
    always_comb begin
        rx_st_d = rx_st_q; rx_cnt_d = rx_cnt_q + 1'b1; rx_bit_d = rx_bit_q;
        rx_sh_d = rx_sh_q; rx_valid_d = 1'b0;
        case (rx_st_q)
            S_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) rx_st_d = S_START;
            end
            S_START: if (rx_cnt_q == HALF_END) begin
                // Glitch filter: line must still be low half a bit later
                rx_cnt_d = '0; rx_bit_d = '0;
                rx_st_d  = rx_s2_q ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_cnt_q == BIT_END) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 1'b1;
                if (rx_bit_q == 3'd7) rx_st_d = S_STOP;
            end
            default: if (rx_cnt_q == BIT_END) begin
                // Back to idle mid stop bit so the next start edge is not missed
                rx_st_d    = S_IDLE;
                rx_valid_d = rx_s2_q;
            end
        endcase
    end

    // ---------------- parser / ALU ----------------
    assign rx_hex = hex_val(rx_sh_q);
    assign ext_a  = sgn_q ? {{OP_W{a_q[OP_W-1]}}, a_q} : {{OP_W{1'b0}}, a_q};
    assign ext_b  = sgn_q ? {{OP_W{b_q[OP_W-1]}}, b_q} : {{OP_W{1'b0}}, b_q};

    always_comb begin
        p_st_d = p_st_q; a_d = a_q; b_d = b_q; sgn_d = sgn_q; op_d = op_q;
        ndig_d = ndig_q; res_d = res_q; err_d = err_q; idx_d = idx_q; bad = 1'b0;
        case (p_st_q)
            P_WAIT_I: if (rx_valid_q && rx_sh_q == "I") p_st_d = P_SP1;
            P_SP1: if (rx_valid_q) begin
                if (rx_sh_q == " ") p_st_d = P_MODE; else bad = 1'b1;
            end
            P_MODE: if (rx_valid_q) begin
                if (rx_sh_q == "S" || rx_sh_q == "s") begin sgn_d = 1'b1; p_st_d = P_SP2; end
                else if (rx_sh_q == "U" || rx_sh_q == "u") begin sgn_d = 1'b0; p_st_d = P_SP2; end
                else bad = 1'b1;
            end
            P_SP2: if (rx_valid_q) begin
                if (rx_sh_q == " ") begin p_st_d = P_OPA; ndig_d = '0; end else bad = 1'b1;
            end
            P_OPA: if (rx_valid_q) begin
                if (rx_hex[4]) begin
                    if (ndig_q == 4'(NDIG)) bad = 1'b1;
                    else begin a_d = {a_q[OP_W-5:0], rx_hex[3:0]}; ndig_d = ndig_q + 1'b1; end
                end else if (ndig_q != '0 && (rx_sh_q == "+" || rx_sh_q == "-" || rx_sh_q == "*")) begin
                    op_d   = (rx_sh_q == "+") ? OP_ADD : (rx_sh_q == "-") ? OP_SUB : OP_MUL;
                    ndig_d = '0;
                    p_st_d = P_OPB;
                end else bad = 1'b1;
            end
            P_OPB: if (rx_valid_q) begin
                if (rx_hex[4]) begin
                    if (ndig_q == 4'(NDIG)) bad = 1'b1;
                    else begin b_d = {b_q[OP_W-5:0], rx_hex[3:0]}; ndig_d = ndig_q + 1'b1; end
                end else if (ndig_q != '0 && rx_sh_q == "=") p_st_d = P_CALC;
                else bad = 1'b1;
            end
            P_CALC: begin
                // Operands extended to result width, so the truncated product is exact
                case (op_q)
                    OP_ADD:  res_d = ext_a + ext_b;
                    OP_SUB:  res_d = ext_a - ext_b;
                    default: res_d = ext_a * ext_b;
                endcase
                err_d = 1'b0; idx_d = '0; p_st_d = P_SEND;
            end
            P_SEND: if (tx_ready) begin
                idx_d = idx_q + 1'b1;
                if (idx_q == (err_q ? IW'(2) : IW'(NCHR + 1))) p_st_d = P_DRAIN;
            end
            default: if (tx_st_q == S_IDLE) begin
                // Last stop bit finished: accept input again
                a_d = '0; b_d = '0; p_st_d = P_WAIT_I;
            end
        endcase
        if (bad) begin
            a_d = '0; b_d = '0; err_d = 1'b1; idx_d = '0; p_st_d = P_SEND;
        end
    end

    // Parser outputs: byte to launch when the transmitter can take it
    assign rsh = res_q << {idx_q, 2'b00};
    always_comb begin
        tx_start = (p_st_q == P_SEND) && tx_ready;
        tx_byte  = 8'h0A;
        if (err_q) begin
            if (idx_q == '0) tx_byte = "E";
            else if (idx_q == IW'(1)) tx_byte = 8'h0D;
        end else if (idx_q < IW'(NCHR)) tx_byte = hex_chr(rsh[RW-1 -: 4]);
        else if (idx_q == IW'(NCHR)) tx_byte = 8'h0D;
    end

    // ---------------- UART TX ----------------
    // Ready on the last stop-bit cycle too, giving gapless back-to-back bytes
    assign tx_ready = (tx_st_q == S_IDLE) || (tx_st_q == S_STOP && tx_cnt_q == BIT_END);

    always_comb begin
        tx_st_d = tx_st_q; tx_cnt_d = tx_cnt_q + 1'b1; tx_bit_d = tx_bit_q; tx_sh_d = tx_sh_q;
        case (tx_st_q)
            S_IDLE:  tx_cnt_d = '0;
            S_START: if (tx_cnt_q == BIT_END) begin
                tx_cnt_d = '0; tx_bit_d = '0; tx_st_d = S_DATA;
            end
            S_DATA: if (tx_cnt_q == BIT_END) begin
                tx_cnt_d = '0; tx_sh_d = {1'b0, tx_sh_q[7:1]}; tx_bit_d = tx_bit_q + 1'b1;
                if (tx_bit_q == 3'd7) tx_st_d = S_STOP;
            end
            default: if (tx_cnt_q == BIT_END) tx_st_d = S_IDLE;
        endcase
        if (tx_start) begin
            tx_st_d = S_START; tx_cnt_d = '0; tx_sh_d = tx_byte;
        end
    end

    always_comb begin
        case (tx_st_q)
            S_START: txd = 1'b0;
            S_DATA:  txd = tx_sh_q[0];
            default: txd = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_calc_top.sv
module tb_uart_calc_top;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd = 1'b1;
    logic txd;

    uart_calc_top #(.CLKS_PER_BIT(CPB), .OP_W(16)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .txd(txd)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, rst_cnt = 0, trig_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge rst) rst_cnt <= rst_cnt + 1;

    typedef struct { logic [7:0] ch; bit first; bit lat; } exp_t;
    exp_t exp_q[$];

    // Expected reply from the arithmetic rules, formatted as uppercase hex + CRLF
    function automatic string model_resp(bit sgn, logic [15:0] a, logic [15:0] b, byte op);
        longint ea, eb, r;
        logic [31:0] r32;
        logic [3:0] n;
        string s;
        ea = sgn ? longint'($signed(a)) : longint'(a);
        eb = sgn ? longint'($signed(b)) : longint'(b);
        if (op == "+") r = ea + eb;
        else if (op == "-") r = ea - eb;
        else r = ea * eb;
        r32 = r[31:0];
        s = "00000000\r\n";
        for (int i = 0; i < 8; i++) begin
            n = r32[31 - 4*i -: 4];
            s.putc(i, (n < 10) ? byte'(8'h30 + n) : byte'(8'h37 + n));
        end
        return s;
    endfunction

    task automatic check_bit(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b want=%b", name, act, exp);
        end
    endtask

    task automatic check_str(string name, string act, string exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%s want=%s", name, act.substr(0, 7), exp.substr(0, 7));
        end
    endtask

    // Monitor: decodes every txd frame and compares against the expected queue
    initial begin : mon
        logic prev;
        logic [7:0] d;
        logic st0, stp;
        int sc, rc, last_sc;
        exp_t e;
        prev = 1'b1;
        last_sc = 0;
        forever begin
            @(negedge clk);
            if (!rst && prev && !txd) begin
                sc = cyc; rc = rst_cnt;
                repeat (CPB/2) @(negedge clk);
                st0 = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                stp = txd;
                if (rc == rst_cnt && !rst) begin
                    checks++;
                    if (st0 !== 1'b0 || stp !== 1'b1) begin
                        failures++;
                        $display("FAIL framing start=%b stop=%b", st0, stp);
                    end
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_tx_byte got=%h want=none", d);
                    end else begin
                        e = exp_q.pop_front();
                        if (d !== e.ch) begin
                            failures++;
                            $display("FAIL tx_byte got=%h want=%h", d, e.ch);
                        end
                        if (!e.first) begin
                            checks++;
                            if (sc - last_sc != 10*CPB) begin
                                failures++;
                                $display("FAIL byte_spacing got=%0d want=%0d", sc - last_sc, 10*CPB);
                            end
                        end else if (e.lat) begin
                            checks++;
                            if (sc - trig_cyc > CPB/2 + 8) begin
                                failures++;
                                $display("FAIL resp_latency got=%0d want<=%0d", sc - trig_cyc, CPB/2 + 8);
                            end
                        end
                    end
                    last_sc = sc;
                end
                prev = txd;
            end else begin
                prev = txd;
            end
        end
    end

    task automatic send_byte(logic [7:0] b, bit good_stop);
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        trig_cyc = cyc;
        rxd = good_stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic send_str(string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic push_resp(string r, bit lat);
        exp_t e;
        for (int i = 0; i < r.len(); i++) begin
            e.ch = r[i]; e.first = (i == 0); e.lat = lat && (i == 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_resp(string name, int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout got=%0d_pending want=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2*CPB) @(negedge clk);
    endtask

    task automatic run_cmd(string cmd, bit sgn, logic [15:0] a, logic [15:0] b, byte op);
        push_resp(model_resp(sgn, a, b, op), 1'b1);
        send_str(cmd);
        wait_resp(cmd, 150*CPB);
    endtask

    initial begin
        int n;
        rst = 1'b1; rxd = 1'b1;
        repeat (5) @(negedge clk);
        check_bit("txd_in_reset", txd, 1'b1);
        rst = 1'b0;
        repeat (2*CPB) @(negedge clk);
        check_bit("txd_idle", txd, 1'b1);

        // Pin the model against hand-computed replies
        check_str("model_s_sub", model_resp(1, 16'hbbb5, 16'hbbb7, "-"), "FFFFFFFE\r\n");
        check_str("model_s_sub2", model_resp(1, 16'hfff3, 16'h0004, "-"), "FFFFFFEF\r\n");
        check_str("model_u_mul", model_resp(0, 16'hffff, 16'hffff, "*"), "FFFE0001\r\n");
        check_str("model_s_mul", model_resp(1, 16'hffff, 16'hffff, "*"), "00000001\r\n");
        check_str("model_u_wrap", model_resp(0, 16'h0000, 16'h0001, "-"), "FFFFFFFF\r\n");

        run_cmd("I S bbb5-bbb7=", 1, 16'hbbb5, 16'hbbb7, "-");
        repeat (2400) @(negedge clk);
        run_cmd("I S fff3-0004=", 1, 16'hfff3, 16'h0004, "-");
        run_cmd("I U ffff*ffff=", 0, 16'hffff, 16'hffff, "*");
        run_cmd("I S ffff*ffff=", 1, 16'hffff, 16'hffff, "*");
        run_cmd("I S 7fff+0001=", 1, 16'h7fff, 16'h0001, "+");
        run_cmd("I U 12+3=", 0, 16'h0012, 16'h0003, "+");
        run_cmd("I u 0000-0001=", 0, 16'h0000, 16'h0001, "-");
        run_cmd("I s 8000*7FfF=", 1, 16'h8000, 16'h7fff, "*");

        // Malformed expressions; trailing bytes arrive while "E\r\n" is sent
        push_resp("E\r\n", 1'b0); send_str("I S 12g4="); wait_resp("err_hex", 150*CPB);
        push_resp("E\r\n", 1'b0); send_str("I U 12345+1="); wait_resp("err_5dig", 150*CPB);
        push_resp("E\r\n", 1'b0); send_str("I X 1+1="); wait_resp("err_mode", 150*CPB);
        push_resp("E\r\n", 1'b0); send_str("I S +1="); wait_resp("err_nodig", 150*CPB);
        run_cmd("I U aB+Cd=", 0, 16'h00ab, 16'h00cd, "+");

        // Bad stop bit on 'I': the whole command must go unanswered
        send_byte("I", 1'b0);
        send_str(" S 7fff+0001=");
        repeat (120*CPB) @(negedge clk);
        check_bit("txd_after_bad_stop", txd, 1'b1);

        // Reset in the middle of an incoming byte after a partial command
        send_str("I S 1+");
        @(negedge clk); rxd = 1'b0;
        repeat (4*CPB) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_bit("txd_rst_mid_rx", txd, 1'b1);
        rxd = 1'b1; rst = 1'b0;
        send_str("2=");
        repeat (120*CPB) @(negedge clk);
        check_bit("txd_after_rx_rst", txd, 1'b1);
        run_cmd("I S 7fff+0001=", 1, 16'h7fff, 16'h0001, "+");

        // Reset in the middle of a reply
        push_resp(model_resp(0, 16'hffff, 16'hffff, "*"), 1'b1);
        send_str("I U ffff*ffff=");
        n = 0;
        while (exp_q.size() > 7 && n < 100*CPB) begin @(negedge clk); n++; end
        checks++;
        if (exp_q.size() > 7) begin
            failures++;
            $display("FAIL reply_start_timeout got=%0d_pending want<=7", exp_q.size());
        end
        repeat (3*CPB) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check_bit("txd_rst_mid_tx", txd, 1'b1);
        rst = 1'b0;
        repeat (120*CPB) @(negedge clk);
        check_bit("txd_after_tx_rst", txd, 1'b1);
        run_cmd("I U 12+3=", 0, 16'h0012, 16'h0003, "+");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
